// File: rtl/rx_pkg.sv
// +-----------------------------------------------------------------------+
// | rx_pkg: shared state encodings and data width for the receive path.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package rx_pkg;

  localparam int RX_DATA_W = 2;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t RST_STATE   = 2'b00;
  localparam rx_state_t RX_STATE    = 2'b01;
  localparam rx_state_t FLUSH_STATE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rx_buffer_sync_fifo.sv
// +-----------------------------------------------------------------------+
// | sync_fifo: show-ahead FIFO with push/pop/clear and occupancy count.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sync_fifo
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [OCC_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + OCC_W'(push_i) - OCC_W'(pop_i);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rx_buffer.sv
// +-----------------------------------------------------------------------+
// | rx_buffer: valid/ready receive buffer with flush and traffic counter. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rx_buffer
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              flush_i,
  output logic [OCC_W-1:0]  count_o,
  output logic [CNT_W-1:0]  rx_total_o
);

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  rx_total_q, rx_total_d;
  logic [OCC_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              push, pop, clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RST_STATE;
    case (state_q)
      RST_STATE:   state_d = RX_STATE;
      RX_STATE:    state_d = flush_i ? FLUSH_STATE : RX_STATE;
      FLUSH_STATE: state_d = RX_STATE;
      default:     state_d = RST_STATE;
    endcase
  end

  // Handshakes depend only on registered state/count (rst just masks them).
  always_comb begin
    ready_o = !rst && (state_q == RX_STATE) && (fifo_count < FULL_CNT);
    valid_o = !rst && (state_q == RX_STATE) && (fifo_count != '0);
    data_o  = rst ? '0 : fifo_data;
  end

  assign push  = valid_i && ready_o;
  assign pop   = valid_o && ready_i;
  assign clear = (state_q == FLUSH_STATE);

  assign rx_total_d = rx_total_q + CNT_W'(push);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_total_q <= '0;
    end else begin
      rx_total_q <= rx_total_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (data_i),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign count_o    = fifo_count;
  assign rx_total_o = rx_total_q;

endmodule

`default_nettype wire
